muntjac_csr_access_ctrl: RTL and testbench
==========================================

// Module: muntjac_csr_access_ctrl
// PURPOSE
// - Sequences CSR read-modify-write accesses (CSRRW/CSRRS/CSRRC/read) onto a single-ported CSR storage array.
// - Arbitrates between two requesters: the core pipeline (requester 0) and the debug module (requester 1).
// - Performs the privilege and read-only checks implied by CSR address bits [11:8].
// - Sits between the execute stage / debug module and the CSR register file.
// PARAMETERS
// - XLEN, 64: CSR data width.
// PORTS
// clk_i            in   1     clock
// rst_ni           in   1     asynchronous active-low reset
// req_valid_i      in   2     per-requester request valid; [0]=core, [1]=debug
// req_ready_o      out  2     per-requester accept; at most one bit set
// req_addr_i       in   2x12  CSR address (csr_t)
// req_op_i         in   2x2   csr_op_e: READ, RW, RS, RC
// req_wdata_i      in   2xXLEN  write data / set-clear mask
// req_priv_i       in   2x2   privilege of requester (debug input ignored, treated as M)
// resp_valid_o     out  1     response valid
// resp_ready_i     in   1     response accept
// resp_id_o        out  1     requester that owns the response
// resp_rdata_o     out  XLEN  old CSR value (0 on exception)
// resp_illegal_o   out  1     access raised an illegal-instruction exception
// csr_re_o         out  1     storage read strobe
// csr_we_o         out  1     storage write strobe
// csr_addr_o       out  12    storage address
// csr_wdata_o      out  XLEN  storage write data
// csr_rdata_i      in   XLEN  storage read data, valid the cycle after csr_re_o
// csr_unimpl_i     in   1     address unimplemented, valid alongside csr_rdata_i
// mcounteren_i     in   32    mcounteren (used only with the macro)
// scounteren_i     in   32    scounteren (used only with the macro)
// BEHAVIOUR
// - Reset values: all outputs 0; FSM in IDLE; round-robin pointer favours core.
// - FSM states:
//   - IDLE:
//     - req_ready_o = grant vector; a request is accepted on valid & ready.
//     - On accept, latch addr, op, wdata, id and eff_priv, then run the pre-check.
//     - Pre-check fails: go to RESP. Otherwise go to READ.
//   - READ: csr_re_o=1 and csr_addr_o=latched addr for exactly one cycle; go to WRITE.
//   - WRITE:
//     - Capture csr_rdata_i.
//     - If csr_unimpl_i is set: illegal, no write.
//     - Else if the access has write intent: csr_we_o=1 for one cycle, new value = RW: wdata; RS: old|wdata; RC: old&~wdata.
//     - Go to RESP.
//   - RESP: resp_valid_o held with stable data until resp_ready_i; then return to IDLE.
// - Write intent: RW always; RS/RC only if wdata!=0; READ never.
// - Pre-check is illegal if either:
//   - addr[9:8] > eff_priv; or
//   - addr[11:10]==2'b11 and the access has write intent.
// - eff_priv = M for the debug requester.
// - Latency: accept -> resp_valid_o is 3 cycles legal, 1 cycle pre-check illegal.
// - Illegal accesses:
//   - csr_we_o is never asserted; resp_rdata_o=0, resp_illegal_o=1.
//   - A pre-check-illegal access never asserts csr_re_o.
// - Arbitration:
//   - Round-robin between the two requesters; the grant is given only in IDLE.
//   - After a grant to X, the other requester wins the next tie.
//   - A single requesting side always wins.
// - Requesters hold valid and payload stable until ready (not checked).
// - Reset mid-operation: return to IDLE immediately, no pending write completes, response dropped.
// CONFIGURATION
// - MUNTJAC_CSR_COUNTEREN_EN defined: additional pre-check for addr in CSR_CYCLE..CSR_HPMCOUNTER31, i=addr[4:0]:
//   - eff_priv==U: illegal unless mcounteren_i[i] & scounteren_i[i].
//   - eff_priv==S: illegal unless mcounteren_i[i].
//   - Debug requester is exempt.
// - MUNTJAC_CSR_COUNTEREN_EN undefined: no counter gating; mcounteren_i/scounteren_i are unused.
// STRUCTURE
// - Shared riscv package: csr_op_e {CSR_OP_READ, CSR_OP_RW, CSR_OP_RS, CSR_OP_RC}; priv_lvl_e {PRIV_U=0, PRIV_S=1, PRIV_M=3}.
// - The csr_t address constants stay in the shared riscv package.
// - FSM state enum is local to the module.
// - Sub-module muntjac_rr_arb2: two-input round-robin arbiter (req[1:0], advance, gnt[1:0]).
// TESTING
// 1. Core RS: mstatus=0x8, req addr=0x300, wdata=0x2, priv=M -> csr_re_o at +1, csr_we_o at +2 with wdata=0xA; response rdata=0x8, illegal=0, at +3.
// 2. Core RW to CSR_MVENDORID (0xF11), priv=M -> response at +1 with illegal=1, rdata=0; csr_re_o and csr_we_o never asserted.
// 3. Core RS with wdata=0 to CSR_CYCLE (0xC00), priv=M -> csr_re_o asserted, csr_we_o never asserted; rdata=cycle value, illegal=0.
// 4. Core and debug both valid in three back-to-back rounds -> grants alternate core, debug, core; resp_id_o matches each grant.
// 5. Core RW to CSR_SATP (0x180) at priv=U -> illegal at +1. Same request from the debug requester -> legal, write performed.
// 6. With MUNTJAC_CSR_COUNTEREN_EN: priv=S read of 0xC02 with mcounteren=0 -> illegal; with mcounteren[2]=1 -> legal. Assert rst_ni low while in WRITE -> no csr_we_o, all outputs return to 0.

Source files
------------

// File: rtl/muntjac_csr_access_ctrl_pkg.sv
// Shared CSR definitions: access ops, privilege levels and the CSR addresses the
// access controller refers to.
package muntjac_csr_access_ctrl_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } priv_lvl_e;

    typedef logic [11:0] csr_t;

    localparam csr_t CSR_SATP         = 12'h180;
    localparam csr_t CSR_MSTATUS      = 12'h300;
    localparam csr_t CSR_CYCLE        = 12'hC00;
    localparam csr_t CSR_HPMCOUNTER31 = 12'hC1F;
    localparam csr_t CSR_MVENDORID    = 12'hF11;

    // Set/clear with an all-zero mask is a pure read and must not touch the CSR.
    function automatic logic csr_write_intent(csr_op_e op, logic wdata_nz);
        unique case (op)
            CSR_OP_RW:           return 1'b1;
            CSR_OP_RS, CSR_OP_RC: return wdata_nz;
            default:             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muntjac_csr_access_ctrl_rr_arb.sv
// Two-input round-robin arbiter: a lone request always wins, and a tie goes to the
// side that did not win the previous advance.
module muntjac_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic prio_q, prio_d;  // 1: requester 1 wins a tie

    always_comb begin
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
        prio_d = prio_q;
        if (advance_i && (gnt_o != 2'b00)) begin
            prio_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/muntjac_csr_access_ctrl.sv
// CSR read-modify-write sequencer for core and debug requesters with privilege checks.
// Optional counter gating via mcounteren/scounteren: define MUNTJAC_CSR_COUNTEREN_EN.
module muntjac_csr_access_ctrl
    import muntjac_csr_access_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  logic [1:0][11:0]     req_addr_i,
    input  logic [1:0][1:0]      req_op_i,
    input  logic [1:0][XLEN-1:0] req_wdata_i,
    input  logic [1:0][1:0]      req_priv_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic                 resp_id_o,
    output logic [XLEN-1:0]      resp_rdata_o,
    output logic                 resp_illegal_o,
    output logic                 csr_re_o,
    output logic                 csr_we_o,
    output logic [11:0]          csr_addr_o,
    output logic [XLEN-1:0]      csr_wdata_o,
    input  logic [XLEN-1:0]      csr_rdata_i,
    input  logic                 csr_unimpl_i,
    input  logic [31:0]          mcounteren_i,
    input  logic [31:0]          scounteren_i
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e          state_q, state_d;
    csr_t            addr_q, addr_d;
    csr_op_e         op_q, op_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            id_q, id_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic [1:0]      gnt;
    logic            sel;
    csr_t            in_addr;
    csr_op_e         in_op;
    logic [XLEN-1:0] in_wdata;
    logic [1:0]      in_priv;
    logic            pre_illegal;
    logic [XLEN-1:0] new_val;

    muntjac_rr_arb2 u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    ((state_q == StIdle) ? req_valid_i : 2'b00),
        .advance_i((state_q == StIdle) && (req_valid_i != 2'b00)),
        .gnt_o    (gnt)
    );

    assign req_ready_o = gnt;
    assign sel         = gnt[1];

    always_comb begin
        in_addr     = req_addr_i[sel];
        in_op       = csr_op_e'(req_op_i[sel]);
        in_wdata    = req_wdata_i[sel];
        in_priv     = sel ? PRIV_M : req_priv_i[sel];
        pre_illegal = (in_addr[9:8] > in_priv) ||
                      ((in_addr[11:10] == 2'b11) && csr_write_intent(in_op, |in_wdata));
`ifdef MUNTJAC_CSR_COUNTEREN_EN
        if (!sel && (in_addr >= CSR_CYCLE) && (in_addr <= CSR_HPMCOUNTER31)) begin
            if ((in_priv == PRIV_U) &&
                !(mcounteren_i[in_addr[4:0]] && scounteren_i[in_addr[4:0]])) begin
                pre_illegal = 1'b1;
            end
            if ((in_priv == PRIV_S) && !mcounteren_i[in_addr[4:0]]) begin
                pre_illegal = 1'b1;
            end
        end
`endif
    end

`ifndef MUNTJAC_CSR_COUNTEREN_EN
    logic unused_counteren;
    assign unused_counteren = ^{mcounteren_i, scounteren_i};
`endif

    always_comb begin
        case (op_q)
            CSR_OP_RW: new_val = wdata_q;
            CSR_OP_RS: new_val = csr_rdata_i | wdata_q;
            CSR_OP_RC: new_val = csr_rdata_i & ~wdata_q;
            default:   new_val = csr_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        id_d        = id_q;
        illegal_d   = illegal_q;
        rdata_d     = rdata_q;
        csr_we_o    = 1'b0;
        csr_wdata_o = '0;
        unique case (state_q)
            StIdle: begin
                if (gnt != 2'b00) begin
                    addr_d    = in_addr;
                    op_d      = in_op;
                    wdata_d   = in_wdata;
                    id_d      = sel;
                    illegal_d = pre_illegal;
                    rdata_d   = '0;
                    state_d   = pre_illegal ? StResp : StRead;
                end
            end
            StRead: state_d = StWrite;
            StWrite: begin
                // Storage data arrives this cycle, so the write strobe is combinational.
                illegal_d = csr_unimpl_i;
                rdata_d   = csr_unimpl_i ? '0 : csr_rdata_i;
                if (!csr_unimpl_i && csr_write_intent(op_q, |wdata_q)) begin
                    csr_we_o    = 1'b1;
                    csr_wdata_o = new_val;
                end
                state_d = StResp;
            end
            StResp: begin
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            op_q      <= CSR_OP_READ;
            wdata_q   <= '0;
            id_q      <= 1'b0;
            illegal_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            wdata_q   <= wdata_d;
            id_q      <= id_d;
            illegal_q <= illegal_d;
            rdata_q   <= rdata_d;
        end
    end

    assign csr_re_o       = (state_q == StRead);
    assign csr_addr_o     = addr_q;
    assign resp_valid_o   = (state_q == StResp);
    assign resp_id_o      = id_q;
    assign resp_rdata_o   = rdata_q;
    assign resp_illegal_o = illegal_q;

endmodule

// File: tb/tb_muntjac_csr_access_ctrl.sv
// Randomised bench for muntjac_csr_access_ctrl against a transaction-level CSR model.
module tb_muntjac_csr_access_ctrl;
    import muntjac_csr_access_ctrl_pkg::*;

    localparam int unsigned XLEN = 64;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [1:0]           req_valid_i;
    logic [1:0]           req_ready_o;
    logic [1:0][11:0]     req_addr_i;
    logic [1:0][1:0]      req_op_i;
    logic [1:0][XLEN-1:0] req_wdata_i;
    logic [1:0][1:0]      req_priv_i;
    logic                 resp_valid_o;
    logic                 resp_ready_i;
    logic                 resp_id_o;
    logic [XLEN-1:0]      resp_rdata_o;
    logic                 resp_illegal_o;
    logic                 csr_re_o;
    logic                 csr_we_o;
    logic [11:0]          csr_addr_o;
    logic [XLEN-1:0]      csr_wdata_o;
    logic [XLEN-1:0]      csr_rdata_i;
    logic                 csr_unimpl_i;
    logic [31:0]          mcounteren_i;
    logic [31:0]          scounteren_i;

    muntjac_csr_access_ctrl #(.XLEN(XLEN)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_op_i      (req_op_i),
        .req_wdata_i   (req_wdata_i),
        .req_priv_i    (req_priv_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_id_o     (resp_id_o),
        .resp_rdata_o  (resp_rdata_o),
        .resp_illegal_o(resp_illegal_o),
        .csr_re_o      (csr_re_o),
        .csr_we_o      (csr_we_o),
        .csr_addr_o    (csr_addr_o),
        .csr_wdata_o   (csr_wdata_o),
        .csr_rdata_i   (csr_rdata_i),
        .csr_unimpl_i  (csr_unimpl_i),
        .mcounteren_i  (mcounteren_i),
        .scounteren_i  (scounteren_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks;
    int n_errors;

    logic [63:0] mem       [4096];
    logic [63:0] model_mem [4096];

    logic        pend_v    [2];
    logic [11:0] pend_addr [2];
    logic [1:0]  pend_op   [2];
    logic [63:0] pend_wd   [2];
    logic [1:0]  pend_priv [2];
    int          last_win;

    logic [11:0] pool [10] = '{12'h300, 12'h305, 12'h180, 12'h100, 12'h040,
                               12'hC00, 12'hC02, 12'hF11, 12'h7C0, 12'h5C0};

    function automatic logic [63:0] init_val(logic [11:0] a);
        return (a == 12'h300) ? 64'h8 : {4{4'hA, a}};
    endfunction

    function automatic logic is_unimpl(logic [11:0] a);
        return (a == 12'h7C0) || (a == 12'h5C0);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // CSR storage: one-cycle read latency, writes land on the strobe edge.
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = init_val(12'(i));
        csr_rdata_i  <= '0;
        csr_unimpl_i <= 1'b0;
        forever begin
            @(posedge clk_i);
            if (csr_we_o) mem[csr_addr_o] = csr_wdata_o;
            if (csr_re_o) begin
                csr_rdata_i  <= mem[csr_addr_o];
                csr_unimpl_i <= is_unimpl(csr_addr_o);
            end
        end
    end

    task automatic new_req(input int s, input logic [11:0] a, input logic [1:0] op,
                           input logic [63:0] wd, input logic [1:0] pv);
        pend_v[s]    = 1'b1;
        pend_addr[s] = a;
        pend_op[s]   = op;
        pend_wd[s]   = wd;
        pend_priv[s] = pv;
    endtask

    task automatic new_rand_req(input int s);
        int p;
        logic [63:0] wd;
        p  = $urandom_range(0, 2);
        wd = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
        new_req(s, pool[$urandom_range(0, 9)], 2'($urandom_range(0, 3)), wd,
                (p == 2) ? 2'd3 : 2'(p));
    endtask

    task automatic drive_reqs();
        for (int s = 0; s < 2; s++) begin
            req_valid_i[s] = pend_v[s];
            req_addr_i[s]  = pend_addr[s];
            req_op_i[s]    = pend_op[s];
            req_wdata_i[s] = pend_wd[s];
            req_priv_i[s]  = pend_priv[s];
        end
    endtask

    // Called on a negedge with the DUT idle; runs one accepted request to completion.
    task automatic run_round();
        int w, exp_lat, lat, re_at, we_at, we_cnt, hold;
        logic [1:0] exp_gnt, eff, op;
        logic [11:0] a;
        logic [63:0] wd, old, nv, exp_rdata, we_data;
        logic intent, pre_ill, exp_ill, exp_we, got, rdy_bad, addr_bad, hold_bad;

        drive_reqs();
        #1;
        if (pend_v[0] && pend_v[1]) w = (last_win == 0) ? 1 : 0;
        else                        w = pend_v[1] ? 1 : 0;
        exp_gnt = (w == 1) ? 2'b10 : 2'b01;
        check_eq("grant", 64'(req_ready_o), 64'(exp_gnt));

        a   = pend_addr[w];
        op  = pend_op[w];
        wd  = pend_wd[w];
        eff = (w == 1) ? 2'd3 : pend_priv[w];
        intent  = (op == 2'd1) || ((op == 2'd2 || op == 2'd3) && (wd != 0));
        pre_ill = (a[9:8] > eff) || ((a[11:10] == 2'b11) && intent);
`ifdef MUNTJAC_CSR_COUNTEREN_EN
        if (w == 0 && a >= 12'hC00 && a <= 12'hC1F) begin
            if (eff == 2'd0 && !(mcounteren_i[a[4:0]] && scounteren_i[a[4:0]])) pre_ill = 1'b1;
            if (eff == 2'd1 && !mcounteren_i[a[4:0]]) pre_ill = 1'b1;
        end
`endif
        old = model_mem[a];
        case (op)
            2'd1:    nv = wd;
            2'd2:    nv = old | wd;
            2'd3:    nv = old & ~wd;
            default: nv = old;
        endcase
        exp_ill   = pre_ill || is_unimpl(a);
        exp_we    = !exp_ill && intent;
        exp_rdata = exp_ill ? 64'h0 : old;
        exp_lat   = pre_ill ? 1 : 3;
        if (exp_we) model_mem[a] = nv;

        @(posedge clk_i);
        last_win  = w;
        pend_v[w] = 1'b0;
        @(negedge clk_i);
        drive_reqs();

        got = 0; lat = 0; re_at = 0; we_at = 0; we_cnt = 0; we_data = '0;
        rdy_bad = 0; addr_bad = 0;
        for (int c = 1; c <= 6; c++) begin
            if (!got) begin
                if (csr_re_o) begin
                    re_at = (re_at == 0) ? c : 99;
                    if (csr_addr_o != a) addr_bad = 1;
                end
                if (csr_we_o) begin
                    we_cnt++;
                    we_at   = c;
                    we_data = csr_wdata_o;
                    if (csr_addr_o != a) addr_bad = 1;
                end
                if (req_ready_o != 2'b00) rdy_bad = 1;
                if (resp_valid_o) begin
                    got = 1;
                    lat = c;
                end else begin
                    @(negedge clk_i);
                end
            end
        end
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("re_cycle", 64'(re_at), pre_ill ? 64'd0 : 64'd1);
        check_eq("csr_addr", 64'(addr_bad), 64'd0);
        check_eq("we_count", 64'(we_cnt), 64'(exp_we));
        if (exp_we) begin
            check_eq("we_cycle", 64'(we_at), 64'd2);
            check_eq("we_data", we_data, nv);
        end
        check_eq("busy_ready", 64'(rdy_bad), 64'd0);
        check_eq("resp_id", 64'(resp_id_o), 64'(w));
        check_eq("resp_rdata", resp_rdata_o, exp_rdata);
        check_eq("resp_illegal", 64'(resp_illegal_o), 64'(exp_ill));

        hold_bad = 0;
        hold = $urandom_range(0, 2);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk_i);
            if (!resp_valid_o || resp_rdata_o != exp_rdata || resp_illegal_o != exp_ill ||
                resp_id_o != 1'(w)) hold_bad = 1;
        end
        check_eq("resp_hold", 64'(hold_bad), 64'd0);
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        check_eq("resp_done", 64'(resp_valid_o), 64'd0);
        check_eq("storage", mem[a], model_mem[a]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_ni = 1'b0;
        resp_ready_i = 1'b0;
        mcounteren_i = '0;
        scounteren_i = '0;
        for (int i = 0; i < 4096; i++) model_mem[i] = init_val(12'(i));
        for (int s = 0; s < 2; s++) new_req(s, 12'h0, 2'd0, 64'h0, 2'd0);
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        last_win = 1;
        drive_reqs();
        repeat (2) @(negedge clk_i);

        check_eq("rst_ready", 64'(req_ready_o), 64'd0);
        check_eq("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check_eq("rst_re", 64'(csr_re_o), 64'd0);
        check_eq("rst_we", 64'(csr_we_o), 64'd0);
        check_eq("rst_addr", 64'(csr_addr_o), 64'd0);
        check_eq("rst_rdata", resp_rdata_o, 64'd0);
        check_eq("rst_illegal", 64'(resp_illegal_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        new_req(0, 12'h300, 2'd2, 64'h2, 2'd3);  run_round();
        check_eq("mstatus_after_rs", mem[12'h300], 64'hA);
        new_req(0, 12'hF11, 2'd1, 64'h5, 2'd3);  run_round();
        new_req(0, 12'hC00, 2'd2, 64'h0, 2'd3);  run_round();
        new_req(0, 12'h180, 2'd1, 64'h1234, 2'd0); run_round();
        new_req(1, 12'h180, 2'd1, 64'h1234, 2'd0); run_round();
        check_eq("satp_debug_write", mem[12'h180], 64'h1234);

        new_req(0, 12'h300, 2'd0, 64'h0, 2'd3);
        new_req(1, 12'h305, 2'd0, 64'h0, 2'd3);
        run_round();
        new_req(0, 12'h100, 2'd0, 64'h0, 2'd1);
        run_round();
        new_req(1, 12'h040, 2'd0, 64'h0, 2'd3);
        run_round();
        while (pend_v[0] || pend_v[1]) run_round();

        for (int r = 0; r < 60; r++) begin
            for (int s = 0; s < 2; s++) begin
                if (!pend_v[s] && $urandom_range(0, 1) == 1) new_rand_req(s);
            end
            if (!pend_v[0] && !pend_v[1]) new_rand_req($urandom_range(0, 1));
            mcounteren_i = $urandom;
            scounteren_i = $urandom;
            run_round();
        end
        for (int d = 0; d < 2; d++) begin
            if (pend_v[0] || pend_v[1]) run_round();
        end

        // Reset while the write strobe is up: the write must be dropped.
        new_req(0, 12'h300, 2'd1, {$urandom, $urandom}, 2'd3);
        drive_reqs();
        @(posedge clk_i);
        pend_v[0] = 1'b0;
        @(negedge clk_i);
        drive_reqs();
        @(negedge clk_i);
        check_eq("pre_rst_we", 64'(csr_we_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_we", 64'(csr_we_o), 64'd0);
        check_eq("mid_rst_re", 64'(csr_re_o), 64'd0);
        check_eq("mid_rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check_eq("mid_rst_addr", 64'(csr_addr_o), 64'd0);
        check_eq("mid_rst_wdata", csr_wdata_o, 64'd0);
        check_eq("mid_rst_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        last_win = 1;
        check_eq("mid_rst_storage", mem[12'h300], model_mem[12'h300]);
        @(negedge clk_i);

        new_req(0, 12'h300, 2'd3, 64'h1, 2'd3);
        new_req(1, 12'h305, 2'd2, 64'h10, 2'd0);
        run_round();
        run_round();

`ifdef MUNTJAC_CSR_COUNTEREN_EN
        mcounteren_i = 32'h0;
        scounteren_i = 32'h0;
        new_req(0, 12'hC02, 2'd0, 64'h0, 2'd1);
        run_round();
        check_eq("cnten_blocked", 64'(resp_illegal_o), 64'd1);
        mcounteren_i = 32'h4;
        new_req(0, 12'hC02, 2'd0, 64'h0, 2'd1);
        run_round();
        check_eq("cnten_allowed", 64'(resp_illegal_o), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
